// File: rtl/ntp_cpu_pkg.sv
// Shared CPU constants and types, reused by fetch, jump control and decode.
package ntp_cpu_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned INS_W  = 24;

    localparam logic [ADDR_W-1:0] RESET_VECTOR = 8'h00;
    localparam logic [INS_W-1:0]  NOP_WORD     = 24'h000000;

    // FILL: no valid fetch in flight (after reset or redirect); RUN: streaming.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } ifu_state_t;

endpackage : ntp_cpu_pkg

// File: rtl/pc_reg.sv
// Program counter register: load has priority over hold; otherwise increments
// with silent wrap at the top of the address space.
module pc_reg #(
    parameter int unsigned       ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_hold,
    input  logic [ADDR_W-1:0] i_load_val,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // PC update: reset, then redirect load, then hold, else next sequential address.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_pc <= RESET_VECTOR;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (!i_hold) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule : pc_reg

// File: rtl/instr_fetch_unit.sv
// Program-counter / instruction-fetch stage in front of a synchronous ROM.
// Redirects squash the in-flight fetch and insert two bubbles; stalls hold state.
// Optional macro IFU_REDIRECT_CNT_EN adds a saturating redirect counter output.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W       = ntp_cpu_pkg::ADDR_W,
    parameter int unsigned       INS_W        = ntp_cpu_pkg::INS_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ntp_cpu_pkg::RESET_VECTOR,
    parameter logic [INS_W-1:0]  NOP_WORD     = ntp_cpu_pkg::NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] jmp_loc,
    input  logic              pc_mux_sel,
    input  logic              stall,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic [INS_W-1:0]  ins,
    output logic [ADDR_W-1:0] Current_Address,
    output logic              ins_valid
`ifdef IFU_REDIRECT_CNT_EN
    ,
    output logic [15:0]       redirect_cnt
`endif
);

    import ntp_cpu_pkg::ifu_state_t;
    import ntp_cpu_pkg::FILL;
    import ntp_cpu_pkg::RUN;

    ifu_state_t        r_state;
    logic [ADDR_W-1:0] r_f_addr;
    logic [INS_W-1:0]  r_ins;
    logic [ADDR_W-1:0] r_addr;
    logic              r_valid;

    logic [ADDR_W-1:0] w_pc;
    logic              w_f_valid;
    logic              w_hold;

    // The state register doubles as the in-flight fetch valid flag.
    assign w_f_valid = (r_state == RUN);
    assign w_hold    = stall && !pc_mux_sel;

    // Re-request the in-flight address while stalled so the ROM output stays
    // aligned with r_f_addr when the stall releases.
    assign imem_addr = w_hold ? r_f_addr : w_pc;

    pc_reg #(
        .ADDR_W       (ADDR_W),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk        (clk),
        .i_reset    (reset),
        .i_load     (pc_mux_sel),
        .i_hold     (stall),
        .i_load_val (jmp_loc),
        .o_pc       (w_pc)
    );

    // Fetch FSM and output registers: reset > redirect (squash) > stall (hold) > stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FILL;
            r_f_addr <= '0;
            r_ins    <= NOP_WORD;
            r_addr   <= '0;
            r_valid  <= 1'b0;
        end else if (pc_mux_sel) begin
            r_state <= FILL;
            r_ins   <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_state  <= RUN;
            r_f_addr <= w_pc;
            r_ins    <= w_f_valid ? imem_rdata : NOP_WORD;
            r_addr   <= r_f_addr;
            r_valid  <= w_f_valid;
        end
    end

    assign ins             = r_ins;
    assign Current_Address = r_addr;
    assign ins_valid       = r_valid;

`ifdef IFU_REDIRECT_CNT_EN
    logic [15:0] r_redirect_cnt;

    // Saturating count of redirects accepted outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_cnt <= '0;
        end else if (pc_mux_sel && (r_redirect_cnt != '1)) begin
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule : instr_fetch_unit
